// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot encode/decode path: widths, the decoder
// FSM state type and the code-to-one-hot expansion helper.
package decoder_pkg;

    // Width of a select code and of the one-hot strobe it expands to.
    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;

    // Cycle counter width; covers any hold or gap length up to 255.
    localparam int CNT_W    = $clog2(256);

    // Decoder sequencing: waiting for a code, driving a strobe, forced-low guard.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Expand a select code into a single set bit at that position.
    function automatic logic [ONEHOT_W-1:0] decodeOneHot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cycle_downcounter.sv
// Loadable down-counter used to time the hold and gap phases. A load always
// wins over a decrement, and a decrement at zero is ignored so the count can
// never wrap to 255.
module cycle_downcounter
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: load a new period, or step down towards zero and stop there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Registered 2-to-4 decoder: an accepted code becomes a one-hot strobe on Y
// for HOLD_CYCLES cycles, then Y is forced low for GAP_CYCLES cycles before
// the next code may be taken. Strobes from consecutive transfers therefore
// never touch each other.
module onehot_strobe_decoder
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_en,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] Y,
    output logic                busy,
    output logic                done
);

    // Counter reload values; the counter counts down to zero inclusive, so a
    // period of N cycles loads N-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

    state_t                r_state;
    state_t                w_nextState;
    logic [ONEHOT_W-1:0]   r_y;
    logic [ONEHOT_W-1:0]   w_nextY;
    logic                  r_done;
    logic                  w_nextDone;
    logic                  r_busy;
    logic                  r_inReady;
    logic                  w_accept;
    logic                  w_cntLoad;
    logic [CNT_W-1:0]      w_cntLoadVal;
    logic                  w_cntDec;
    logic                  w_cntZero;

    // A transfer is only taken while idle and advertising ready.
    assign w_accept = in_valid && r_inReady && (r_state == IDLE);

    cycle_downcounter u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cntLoad),
        .load_val (w_cntLoadVal),
        .dec      (w_cntDec),
        .zero     (w_cntZero)
    );

    // Next-state, next-strobe and counter control for the IDLE/HOLD/GAP sequence.
    always_comb begin
        w_nextState  = r_state;
        w_nextY      = r_y;
        w_nextDone   = 1'b0;
        w_cntLoad    = 1'b0;
        w_cntLoadVal = '0;
        w_cntDec     = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextY = '0;
                if (w_accept) begin
                    w_nextState  = HOLD;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = HOLD_LOAD;
                    w_nextY      = in_en ? decodeOneHot(in_code) : '0;
                end
            end

            HOLD: begin
                if (w_cntZero) begin
                    w_nextY    = '0;
                    w_nextDone = 1'b1;
                    if (HAS_GAP) begin
                        w_nextState  = GAP;
                        w_cntLoad    = 1'b1;
                        w_cntLoadVal = GAP_LOAD;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_cntDec = 1'b1;
                end
            end

            GAP: begin
                w_nextY = '0;
                if (w_cntZero) begin
                    w_nextState = IDLE;
                end else begin
                    w_cntDec = 1'b1;
                end
            end

            default: begin
                w_nextState = IDLE;
                w_nextY     = '0;
            end
        endcase
    end

    // State and output registers; ready/busy follow the state being entered so
    // they are valid in the same cycle as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_y       <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_inReady <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_y       <= w_nextY;
            r_done    <= w_nextDone;
            r_busy    <= (w_nextState != IDLE);
            r_inReady <= (w_nextState == IDLE);
        end
    end

    assign Y        = r_y;
    assign done     = r_done;
    assign busy     = r_busy;
    assign in_ready = r_inReady;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder. Three instances cover the default timing,
// the fastest legal timing (hold 1, no gap) and the longest hold (255). A
// driver pushes the expected strobe of every accepted transfer into a queue;
// a monitor keeps a cycle-level picture of what each transfer should look
// like on the outputs and compares every cycle.
module tb_onehot_strobe_decoder;

    typedef struct {
        logic [3:0] y;
        int         edgeNo;
    } xfer_t;

    // Timing of each instance.
    function automatic int holdOf(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 255);
    endfunction

    function automatic int gapOf(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 1);
    endfunction

    logic       clk;
    logic       rst;
    logic       inValid [3];
    logic [1:0] inCode  [3];
    logic       inEn    [3];
    logic       inReady [3];
    logic [3:0] yOut    [3];
    logic       busyOut [3];
    logic       doneOut [3];

    int    cycle;
    int    cur;
    int    releaseCycle;
    int    checks;
    int    errors;
    xfer_t sbQ[$];
    xfer_t curX;
    bit    haveCur;

    for (genvar g = 0; g < 3; g++) begin : gDut
        onehot_strobe_decoder #(
            .HOLD_CYCLES (holdOf(g)),
            .GAP_CYCLES  (gapOf(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (inValid[g]),
            .in_code  (inCode[g]),
            .in_en    (inEn[g]),
            .in_ready (inReady[g]),
            .Y        (yOut[g]),
            .busy     (busyOut[g]),
            .done     (doneOut[g])
        );
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so transfers can be time-stamped.
    always @(posedge clk) begin
        cycle++;
    end

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d, cycle %0d): got %0h expected %0h", name, cur, cycle, act, exp);
        end
    endtask

    // Expected strobe from the decode rule, computed arithmetically.
    function automatic logic [3:0] expectedY(input logic [1:0] code, input logic en);
        return en ? 4'(1 << code) : 4'b0000;
    endfunction

    // Offer one transfer and hold it until taken; pushes the expected strobe
    // with the edge at which it is accepted.
    task automatic applyStimulus(input logic [1:0] code, input logic en);
        int    waited;
        xfer_t x;
        waited       = 0;
        inValid[cur] = 1'b1;
        inCode[cur]  = code;
        inEn[cur]    = en;
        while (!inReady[cur]) begin
            waited++;
            if (waited > 600) begin
                checkOutput("accept_timeout", waited, 0);
                inValid[cur] = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        x.y      = expectedY(code, en);
        x.edgeNo = cycle + 1;
        sbQ.push_back(x);
        @(negedge clk); #1;
        inValid[cur] = 1'b0;
        inCode[cur]  = 2'($urandom_range(0, 3));
        inEn[cur]    = 1'($urandom_range(0, 1));
    endtask

    // Let the current instance return to idle with no outstanding transfers.
    task automatic waitIdle();
        int waited;
        waited = 0;
        while (!(inReady[cur] && sbQ.size() == 0)) begin
            waited++;
            if (waited > 600) begin
                checkOutput("idle_timeout", waited, 0);
                return;
            end
            @(negedge clk); #1;
        end
        repeat (3) begin
            @(negedge clk); #1;
        end
        checkOutput("drained", int'(haveCur), 0);
    endtask

    // Monitor: per-cycle expected Y/done/busy/in_ready derived from the
    // accepted transfers and the instance's hold/gap lengths.
    always @(negedge clk) begin
        int         h;
        int         g;
        int         rel;
        logic [3:0] eY;
        logic       eDone;
        logic       eBusy;
        logic       eReady;
        if (rst) begin
            sbQ.delete();
            haveCur = 1'b0;
        end else begin
            h = holdOf(cur);
            g = gapOf(cur);
            if (haveCur && (cycle - curX.edgeNo) > h + g) begin
                haveCur = 1'b0;
            end
            if (sbQ.size() > 0 && sbQ[0].edgeNo <= cycle) begin
                checkOutput("accept_edge", cycle, sbQ[0].edgeNo);
                checkOutput("overlap", int'(haveCur), 0);
                curX    = sbQ.pop_front();
                haveCur = 1'b1;
            end
            eY    = 4'b0000;
            eDone = 1'b0;
            eBusy = 1'b0;
            if (haveCur) begin
                rel = cycle - curX.edgeNo;
                if (rel < h) begin
                    eY = curX.y;
                end
                eDone = (rel == h);
                eBusy = (rel < h + g);
            end
            eReady = !eBusy && (cycle > releaseCycle);
            checkOutput("Y", int'(yOut[cur]), int'(eY));
            checkOutput("done", int'(doneOut[cur]), int'(eDone));
            checkOutput("busy", int'(busyOut[cur]), int'(eBusy));
            checkOutput("in_ready", int'(inReady[cur]), int'(eReady));
            checkOutput("onehot0", int'($onehot0(yOut[cur])), 1);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int lastEdge;
        xfer_t x;
        cycle        = 0;
        cur          = 0;
        releaseCycle = 0;
        checks       = 0;
        errors       = 0;
        haveCur      = 1'b0;
        rst          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid[i] = 1'b0;
            inCode[i]  = 2'b00;
            inEn[i]    = 1'b0;
        end

        // Reset values on every instance.
        #3;
        for (int i = 0; i < 3; i++) begin
            cur = i;
            checkOutput("rst_Y", int'(yOut[i]), 0);
            checkOutput("rst_done", int'(doneOut[i]), 0);
            checkOutput("rst_busy", int'(busyOut[i]), 0);
            checkOutput("rst_in_ready", int'(inReady[i]), 0);
        end
        cur = 0;
        repeat (2) @(negedge clk);
        #1;
        rst          = 1'b0;
        releaseCycle = cycle;
        checkOutput("in_ready_before_edge", int'(inReady[0]), 0);

        // Default timing: directed code 10, every code in turn, a disabled transfer.
        applyStimulus(2'b10, 1'b1);
        waitIdle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'(c), 1'b1);
        end
        applyStimulus(2'b11, 1'b0);
        waitIdle();

        // Random transfers with random idle spacing.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); #1;
            end
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0));
        end
        waitIdle();

        // Reset in the second hold cycle: Y drops at once, the transfer is lost.
        applyStimulus(2'b01, 1'b1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_Y", int'(yOut[0]), 0);
        checkOutput("midrst_done", int'(doneOut[0]), 0);
        checkOutput("midrst_busy", int'(busyOut[0]), 0);
        checkOutput("midrst_in_ready", int'(inReady[0]), 0);
        repeat (2) @(negedge clk);
        #1;
        rst          = 1'b0;
        releaseCycle = cycle;
        applyStimulus(2'b11, 1'b1);
        waitIdle();

        // Hold 1 / gap 0: continuous valid with a new code every cycle.
        cur      = 1;
        haveCur  = 1'b0;
        lastEdge = -1;
        for (int i = 0; i < 30; i++) begin
            inValid[1] = 1'b1;
            inCode[1]  = 2'($urandom_range(0, 3));
            inEn[1]    = 1'($urandom_range(0, 3) != 0);
            if (inReady[1]) begin
                x.y      = expectedY(inCode[1], inEn[1]);
                x.edgeNo = cycle + 1;
                sbQ.push_back(x);
                if (lastEdge >= 0) begin
                    checkOutput("throughput", x.edgeNo - lastEdge, holdOf(1) + gapOf(1) + 1);
                end
                lastEdge = x.edgeNo;
            end
            @(negedge clk); #1;
        end
        inValid[1] = 1'b0;
        waitIdle();

        // Hold 255: the strobe must last exactly 255 cycles without wrapping.
        cur     = 2;
        haveCur = 1'b0;
        applyStimulus(2'b01, 1'b1);
        waitIdle();
        applyStimulus(2'b10, 1'b1);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
